// File: rtl/csr_pkg.sv
// Shared CSR addresses, interrupt cause codes, mstatus bit positions and the
// trap sequencer state type used by trap_ctrl and trap_irq_arb.
package csr_pkg;

   localparam int unsigned CSR_AW  = 12;
   localparam int unsigned CAUSE_W = 4;

   localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
   localparam logic [CSR_AW-1:0] CSR_MIE     = 12'h304;
   localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
   localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
   localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
   localparam logic [CSR_AW-1:0] CSR_MIP     = 12'h344;

   localparam logic [CAUSE_W-1:0] CAUSE_MSI = 4'd3;
   localparam logic [CAUSE_W-1:0] CAUSE_MTI = 4'd7;
   localparam logic [CAUSE_W-1:0] CAUSE_MEI = 4'd11;

   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_EPC        = 3'd1,
      ST_CAUSE      = 3'd2,
      ST_STATUS     = 3'd3,
      ST_REDIR      = 3'd4,
      ST_MRET       = 3'd5,
      ST_MRET_REDIR = 3'd6
   } trap_state_e;

endpackage

// File: rtl/trap_irq_arb.sv
// Interrupt source front end: synchronizes irq_ext, masks the three levels
// with mie and picks the winning cause (ext > sw > timer).
module trap_irq_arb
   import csr_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               irq_sw,
   input  logic               irq_timer,
   input  logic               irq_ext,
   input  logic [XLEN-1:0]    csr_mie,
   output logic               any_pend,
   output logic [CAUSE_W-1:0] cause,
   output logic [XLEN-1:0]    mip
);

   logic [SYNC_STAGES-1:0] r_ext_sync;
   logic                   w_ext;
   logic                   w_pend_sw;
   logic                   w_pend_timer;
   logic                   w_pend_ext;
   logic                   w_unused;

   // external source is asynchronous to clk
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ext_sync <= '0;
      end else begin
         r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], irq_ext};
      end
   end

   assign w_ext        = r_ext_sync[SYNC_STAGES-1];
   assign w_pend_sw    = irq_sw    & csr_mie[CAUSE_MSI];
   assign w_pend_timer = irq_timer & csr_mie[CAUSE_MTI];
   assign w_pend_ext   = w_ext     & csr_mie[CAUSE_MEI];
   assign any_pend     = w_pend_sw | w_pend_timer | w_pend_ext;

   always_comb begin
      cause = '0;
      if (w_pend_ext) begin
         cause = CAUSE_MEI;
      end else if (w_pend_sw) begin
         cause = CAUSE_MSI;
      end else if (w_pend_timer) begin
         cause = CAUSE_MTI;
      end
   end

   // mip reports raw (unmasked) levels
   always_comb begin
      mip            = '0;
      mip[CAUSE_MSI] = irq_sw;
      mip[CAUSE_MTI] = irq_timer;
      mip[CAUSE_MEI] = w_ext;
   end

   assign w_unused = ^{csr_mie[XLEN-1:12], csr_mie[10:8], csr_mie[6:4], csr_mie[2:0]};

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates interrupts against MRET and drives
// the CSR write port and fetch redirect. Define TRAP_CTRL_VECTORED_EN to
// honour mtvec vectored mode for interrupts.
module trap_ctrl
   import csr_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              irq_sw,
   input  logic              irq_timer,
   input  logic              irq_ext,
   input  logic [XLEN-1:0]   csr_mstatus,
   input  logic [XLEN-1:0]   csr_mie,
   input  logic [XLEN-1:0]   csr_mtvec,
   input  logic [XLEN-1:0]   csr_mepc,
   input  logic [XLEN-1:0]   pc_i,
   input  logic              pc_valid,
   input  logic              stall,
   input  logic              is_mret,
   output logic [XLEN-1:0]   mip_o,
   output logic              csr_we,
   output logic [CSR_AW-1:0] csr_waddr,
   output logic [XLEN-1:0]   csr_wdata,
   output logic              flush,
   output logic              busy,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc
);

   trap_state_e        r_state;
   trap_state_e        w_next;
   logic [CAUSE_W-1:0] r_cause;
   logic [XLEN-1:0]    r_mstatus;

   logic               r_csr_we;
   logic [CSR_AW-1:0]  r_csr_waddr;
   logic [XLEN-1:0]    r_csr_wdata;
   logic               r_flush;
   logic               r_busy;
   logic               r_redir_valid;
   logic [XLEN-1:0]    r_redir_pc;
   logic [XLEN-1:0]    r_mip;

   logic               w_any_pend;
   logic [CAUSE_W-1:0] w_cause;
   logic [XLEN-1:0]    w_mip;
   logic               w_take_irq;
   logic               w_mret_go;
   logic               w_latch;
   logic               w_csr_we;
   logic [CSR_AW-1:0]  w_csr_waddr;
   logic [XLEN-1:0]    w_csr_wdata;
   logic               w_flush;
   logic               w_redir_valid;
   logic [XLEN-1:0]    w_redir_pc;
   logic [XLEN-1:0]    w_trap_base;
   logic [XLEN-1:0]    w_trap_target;
   logic [XLEN-1:0]    w_trap_status;
   logic [XLEN-1:0]    w_mret_status;
   logic               w_unused;

   trap_irq_arb #(
      .XLEN        (XLEN),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .irq_sw    (irq_sw),
      .irq_timer (irq_timer),
      .irq_ext   (irq_ext),
      .csr_mie   (csr_mie),
      .any_pend  (w_any_pend),
      .cause     (w_cause),
      .mip       (w_mip)
   );

   assign w_take_irq = w_any_pend & csr_mstatus[MSTATUS_MIE] & pc_valid & ~stall
                     & (r_state == ST_IDLE);
   assign w_mret_go  = is_mret & ~stall & (r_state == ST_IDLE);

   // mstatus images written on trap entry and on MRET
   always_comb begin
      w_trap_status               = r_mstatus;
      w_trap_status[MSTATUS_MPIE] = r_mstatus[MSTATUS_MIE];
      w_trap_status[MSTATUS_MIE]  = 1'b0;
      w_mret_status               = csr_mstatus;
      w_mret_status[MSTATUS_MIE]  = csr_mstatus[MSTATUS_MPIE];
      w_mret_status[MSTATUS_MPIE] = 1'b1;
   end

   assign w_trap_base = {csr_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
   // every trap here is an interrupt, so vectored mode always applies
   assign w_trap_target = (csr_mtvec[1:0] == 2'b01)
                        ? w_trap_base + (XLEN'(r_cause) << 2)
                        : w_trap_base;
`else
   assign w_trap_target = w_trap_base;
`endif

   // next state plus the output image of that state, registered below
   always_comb begin
      w_next        = r_state;
      w_latch       = 1'b0;
      w_csr_we      = 1'b0;
      w_csr_waddr   = '0;
      w_csr_wdata   = '0;
      w_flush       = 1'b0;
      w_redir_valid = 1'b0;
      w_redir_pc    = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_mret_go) begin
               w_next      = ST_MRET;
               w_csr_we    = 1'b1;
               w_csr_waddr = CSR_MSTATUS;
               w_csr_wdata = w_mret_status;
               w_flush     = 1'b1;
            end else if (w_take_irq) begin
               w_next      = ST_EPC;
               w_latch     = 1'b1;
               w_csr_we    = 1'b1;
               w_csr_waddr = CSR_MEPC;
               w_csr_wdata = pc_i;
               w_flush     = 1'b1;
            end
         end
         ST_EPC: begin
            w_next      = ST_CAUSE;
            w_csr_we    = 1'b1;
            w_csr_waddr = CSR_MCAUSE;
            w_csr_wdata = {1'b1, (XLEN-1)'(r_cause)};
         end
         ST_CAUSE: begin
            w_next      = ST_STATUS;
            w_csr_we    = 1'b1;
            w_csr_waddr = CSR_MSTATUS;
            w_csr_wdata = w_trap_status;
         end
         ST_STATUS: begin
            w_next        = ST_REDIR;
            w_redir_valid = 1'b1;
            w_redir_pc    = w_trap_target;
         end
         ST_REDIR: begin
            w_next = ST_IDLE;
         end
         ST_MRET: begin
            w_next        = ST_MRET_REDIR;
            w_redir_valid = 1'b1;
            w_redir_pc    = {csr_mepc[XLEN-1:2], 2'b00};
         end
         ST_MRET_REDIR: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_cause       <= '0;
         r_mstatus     <= '0;
         r_csr_we      <= 1'b0;
         r_csr_waddr   <= '0;
         r_csr_wdata   <= '0;
         r_flush       <= 1'b0;
         r_busy        <= 1'b0;
         r_redir_valid <= 1'b0;
         r_redir_pc    <= '0;
         r_mip         <= '0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_cause   <= w_cause;
            r_mstatus <= csr_mstatus;
         end
         r_csr_we      <= w_csr_we;
         r_csr_waddr   <= w_csr_waddr;
         r_csr_wdata   <= w_csr_wdata;
         r_flush       <= w_flush;
         r_busy        <= (w_next != ST_IDLE);
         r_redir_valid <= w_redir_valid;
         r_redir_pc    <= w_redir_pc;
         r_mip         <= w_mip;
      end
   end

   assign mip_o          = r_mip;
   assign csr_we         = r_csr_we;
   assign csr_waddr      = r_csr_waddr;
   assign csr_wdata      = r_csr_wdata;
   assign flush          = r_flush;
   assign busy           = r_busy;
   assign redirect_valid = r_redir_valid;
   assign redirect_pc    = r_redir_pc;

   assign w_unused = ^{csr_mepc[1:0], csr_mtvec[1:0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized
// interrupt traps checked against a rule-level reference model.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        irq_sw, irq_timer, irq_ext;
   logic [31:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc, pc_i;
   logic        pc_valid, stall, is_mret;
   logic [31:0] mip_o;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        flush, busy, redirect_valid;
   logic [31:0] redirect_pc;

   int          checks = 0;
   int          errors = 0;

   // CSR-file model: a write seen after one edge commits at the next edge
   logic        wr_pend;
   logic [11:0] wr_addr;
   logic [31:0] wr_data;

   trap_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .irq_sw         (irq_sw),
      .irq_timer      (irq_timer),
      .irq_ext        (irq_ext),
      .csr_mstatus    (csr_mstatus),
      .csr_mie        (csr_mie),
      .csr_mtvec      (csr_mtvec),
      .csr_mepc       (csr_mepc),
      .pc_i           (pc_i),
      .pc_valid       (pc_valid),
      .stall          (stall),
      .is_mret        (is_mret),
      .mip_o          (mip_o),
      .csr_we         (csr_we),
      .csr_waddr      (csr_waddr),
      .csr_wdata      (csr_wdata),
      .flush          (flush),
      .busy           (busy),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ctl();
      return {28'd0, csr_we, flush, busy, redirect_valid};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (wr_pend) begin
         if (wr_addr == 12'h300) csr_mstatus = wr_data;
         else if (wr_addr == 12'h341) csr_mepc = wr_data;
      end
      wr_pend = csr_we;
      wr_addr = csr_waddr;
      wr_data = csr_wdata;
   endtask

   // reference: trap-entry mstatus image
   function automatic logic [31:0] ref_status(input logic [31:0] ms);
      logic [31:0] r;
      r    = ms & ~32'h88;
      r[7] = ms[3];
      return r;
   endfunction

   // reference: highest-priority enabled source (ext > sw > timer), 0 if none
   function automatic int ref_cause(input logic sw, input logic tm, input logic ex,
                                    input logic [31:0] mie);
      if (ex && mie[11]) return 11;
      if (sw && mie[3])  return 3;
      if (tm && mie[7])  return 7;
      return 0;
   endfunction

   function automatic logic [31:0] ref_target(input logic [31:0] mtvec, input int cause);
      logic [31:0] base;
      base = mtvec & 32'hFFFF_FFFC;
`ifdef TRAP_CTRL_VECTORED_EN
      if (mtvec[1:0] == 2'b01) return base + 32'(cause * 4);
`endif
      return base;
   endfunction

   // called right after the accept edge; walks EPC/CAUSE/STATUS/REDIR/IDLE
   task automatic expect_trap(input string tag, input logic [31:0] pc, input int cause,
                              input logic [31:0] st, input logic [31:0] redir);
      chk({tag, "_epc_ctl"},  ctl(), 32'hE);
      chk({tag, "_epc_addr"}, 32'(csr_waddr), 32'h341);
      chk({tag, "_epc_data"}, csr_wdata, pc);
      step();
      chk({tag, "_cause_ctl"},  ctl(), 32'hA);
      chk({tag, "_cause_addr"}, 32'(csr_waddr), 32'h342);
      chk({tag, "_cause_data"}, csr_wdata, 32'h8000_0000 | 32'(cause));
      step();
      chk({tag, "_st_ctl"},  ctl(), 32'hA);
      chk({tag, "_st_addr"}, 32'(csr_waddr), 32'h300);
      chk({tag, "_st_data"}, csr_wdata, st);
      step();
      chk({tag, "_redir_ctl"}, ctl(), 32'h3);
      chk({tag, "_redir_pc"},  redirect_pc, redir);
      step();
      chk({tag, "_idle_ctl"}, ctl(), 32'h0);
   endtask

   initial begin
      rst = 1'b0;
      {irq_sw, irq_timer, irq_ext, pc_valid, stall, is_mret} = '0;
      {csr_mstatus, csr_mie, csr_mtvec, csr_mepc, pc_i} = '0;
      wr_pend = 1'b0; wr_addr = '0; wr_data = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl", ctl(), 32'h0);
      chk("rst_pc", redirect_pc, 32'h0);
      chk("rst_mip", mip_o, 32'h0);
      rst = 1'b1;
      step();

      // direct timer trap
      csr_mtvec = 32'h100; csr_mie = 32'h80; csr_mstatus = 32'h8;
      pc_i = 32'h2000; pc_valid = 1'b1; irq_timer = 1'b1;
      step();
      chk("timer_mip", mip_o, 32'h80);
      expect_trap("timer", 32'h2000, 7, 32'h80, 32'h100);
      irq_timer = 1'b0;
      step();

      // priority ext over sw; MIE=0 blocks everything
      csr_mstatus = 32'h0; csr_mie = 32'h888; pc_i = 32'h3000;
      irq_sw = 1'b1; irq_ext = 1'b1;
      repeat (4) begin
         step();
         chk("mie0_ctl", ctl(), 32'h0);
      end
      chk("prio_mip", mip_o, 32'h808);
      csr_mstatus = 32'h8;
      step();
      expect_trap("prio", 32'h3000, 11, 32'h80, 32'h100);
      irq_sw = 1'b0; irq_ext = 1'b0;
      repeat (3) step();

      // MRET beats a simultaneous timer interrupt
      csr_mstatus = 32'h80; csr_mepc = 32'h2004; csr_mie = 32'h80;
      pc_i = 32'h2008; irq_timer = 1'b1; is_mret = 1'b1;
      step();
      is_mret = 1'b0;
      chk("mret_ctl", ctl(), 32'hE);
      chk("mret_addr", 32'(csr_waddr), 32'h300);
      chk("mret_data", csr_wdata, 32'h88);
      step();
      chk("mret_redir_ctl", ctl(), 32'h3);
      chk("mret_redir_pc", redirect_pc, 32'h2004);
      step();
      chk("mret_idle_ctl", ctl(), 32'h0);
      step();
      expect_trap("post_mret", 32'h2008, 7, 32'h80, 32'h100);
      irq_timer = 1'b0;
      step();

      // stall / pc_valid gate acceptance
      csr_mstatus = 32'h8; csr_mie = 32'h8; pc_i = 32'h4000;
      irq_sw = 1'b1; stall = 1'b1;
      repeat (3) begin
         step();
         chk("stall_ctl", ctl(), 32'h0);
      end
      stall = 1'b0; pc_valid = 1'b0;
      repeat (2) begin
         step();
         chk("pcv_ctl", ctl(), 32'h0);
      end
      pc_valid = 1'b1;
      step();
      expect_trap("gate", 32'h4000, 3, 32'h80, 32'h100);
      irq_sw = 1'b0;
      step();

      // vectored mtvec with external interrupt
      csr_mstatus = 32'h0; csr_mie = 32'h800; csr_mtvec = 32'h101; pc_i = 32'h5000;
      irq_ext = 1'b1;
      repeat (3) step();
      csr_mstatus = 32'h8;
      step();
`ifdef TRAP_CTRL_VECTORED_EN
      expect_trap("vec", 32'h5000, 11, 32'h80, 32'h12C);
`else
      expect_trap("vec", 32'h5000, 11, 32'h80, 32'h100);
`endif
      irq_ext = 1'b0;
      repeat (3) step();

      // reset asserted during CAUSE
      csr_mstatus = 32'h8; csr_mie = 32'h80; csr_mtvec = 32'h100; pc_i = 32'h6000;
      irq_timer = 1'b1;
      step();
      chk("rstmid_epc_addr", 32'(csr_waddr), 32'h341);
      step();
      chk("rstmid_cause_addr", 32'(csr_waddr), 32'h342);
      #2;
      rst = 1'b0; irq_timer = 1'b0;
      #1;
      chk("rstmid_ctl", ctl(), 32'h0);
      chk("rstmid_waddr", 32'(csr_waddr), 32'h0);
      chk("rstmid_wdata", csr_wdata, 32'h0);
      wr_pend = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (6) begin
         step();
         chk("rstmid_after_ctl", ctl(), 32'h0);
      end

      // randomized traps against the reference model
      for (int it = 0; it < 24; it++) begin
         logic        sw, tm, ex;
         logic [31:0] ms, pc;
         int          c;
         sw = 1'($urandom_range(0, 1));
         tm = 1'($urandom_range(0, 1));
         ex = 1'($urandom_range(0, 1));
         csr_mie     = $urandom;
         csr_mtvec   = $urandom;
         pc          = $urandom;
         pc_i        = pc;
         csr_mstatus = $urandom & ~32'h8;
         irq_sw = sw; irq_timer = tm; irq_ext = ex;
         repeat (4) step();
         chk("rnd_pre_ctl", ctl(), 32'h0);
         chk("rnd_mip", mip_o, (32'(ex) << 11) | (32'(sw) << 3) | (32'(tm) << 7));
         ms          = csr_mstatus | 32'h8;
         csr_mstatus = ms;
         step();
         c = ref_cause(sw, tm, ex, csr_mie);
         if (c != 0) expect_trap("rnd", pc, c, ref_status(ms), ref_target(csr_mtvec, c));
         else chk("rnd_none_ctl", ctl(), 32'h0);
         irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
         csr_mstatus = csr_mstatus & ~32'h8;
         repeat (3) step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
